// File: rtl/cpu_mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory port, with one transaction in flight.
// Compile with ROUND_ROBIN_EN defined for alternating grants under contention; the default is fixed data priority.
module cpu_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_valid,
    input  logic [31:0] inst_addr,
    output logic        inst_req_ack,
    output logic        inst_rsp_valid,
    input  logic        inst_rsp_ack,
    output logic [31:0] inst_rsp_data,
    input  logic        data_rd,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_req_ack,
    output logic        data_rsp_valid,
    input  logic        data_rsp_ack,
    output logic [31:0] data_rsp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_data,
    output logic [31:0] conflict_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        gnt_inst_r;
    logic        gnt_data_r;
    logic        last_gnt_r;     // 1 = data channel was granted last
    logic [31:0] conflict_cnt_r;

    logic        inst_want_s;
    logic        data_want_s;
    logic        both_want_s;
    logic        pick_data_s;
    logic        in_idle_s;
    logic        in_req_s;
    logic        in_rsp_s;
    logic        wen_s;

    assign inst_want_s = inst_req_valid;
    assign data_want_s = data_rd | data_wr;
    assign both_want_s = inst_want_s & data_want_s;
    assign wen_s       = gnt_data_r & data_wr;

    // Outputs are qualified with rst so they read zero while reset is held.
    assign in_idle_s = (state_r == IDLE);
    assign in_req_s  = (state_r == REQ) & ~rst;
    assign in_rsp_s  = (state_r == RSP) & ~rst;

    // Grant selection for the IDLE cycle.
    always_comb begin
        pick_data_s = 1'b0;
        if (both_want_s) begin
`ifdef ROUND_ROBIN_EN
            pick_data_s = ~last_gnt_r;
`else
            pick_data_s = 1'b1;
`endif
        end else begin
            pick_data_s = data_want_s;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (inst_want_s | data_want_s) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_nxt_s = wen_s ? IDLE : RSP;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            RSP: begin
                if (mem_rsp_valid & mem_rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RSP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, grant, last-grant and contention counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            gnt_inst_r     <= 1'b0;
            gnt_data_r     <= 1'b0;
            last_gnt_r     <= 1'b1;
            conflict_cnt_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (in_idle_s && (inst_want_s || data_want_s)) begin
                gnt_data_r <= pick_data_s;
                gnt_inst_r <= ~pick_data_s;
                last_gnt_r <= pick_data_s;
            end
            if (in_idle_s && both_want_s) begin
                conflict_cnt_r <= conflict_cnt_r + 32'd1;
            end
        end
    end

    assign mem_req_valid = in_req_s;
    assign mem_addr      = ~in_req_s   ? 32'd0 :
                           gnt_data_r  ? data_addr :
                           gnt_inst_r  ? inst_addr : 32'd0;
    assign mem_wen       = in_req_s & wen_s;
    assign mem_wdata     = (in_req_s & wen_s) ? data_wdata : 32'd0;
    assign mem_wstrb     = (in_req_s & wen_s) ? data_wstrb : 4'd0;

    assign inst_req_ack  = in_req_s & gnt_inst_r & mem_req_ready;
    assign data_req_ack  = in_req_s & gnt_data_r & mem_req_ready;

    assign mem_rsp_ready  = in_rsp_s & ((gnt_inst_r & inst_rsp_ack) | (gnt_data_r & data_rsp_ack));
    assign inst_rsp_valid = in_rsp_s & gnt_inst_r & mem_rsp_valid;
    assign data_rsp_valid = in_rsp_s & gnt_data_r & mem_rsp_valid;
    assign inst_rsp_data  = in_rsp_s ? mem_rsp_data : 32'd0;
    assign data_rsp_data  = in_rsp_s ? mem_rsp_data : 32'd0;

    assign conflict_cnt   = rst ? 32'd0 : conflict_cnt_r;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed self-checking bench for cpu_mem_arbiter; the downstream memory is driven by hand per cycle.
module tb_cpu_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req_valid;
    logic [31:0] inst_addr;
    logic        inst_req_ack;
    logic        inst_rsp_valid;
    logic        inst_rsp_ack;
    logic [31:0] inst_rsp_data;
    logic        data_rd;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_req_ack;
    logic        data_rsp_valid;
    logic        data_rsp_ack;
    logic [31:0] data_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_data;
    logic [31:0] conflict_cnt;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    cpu_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req_valid(inst_req_valid), .inst_addr(inst_addr), .inst_req_ack(inst_req_ack),
        .inst_rsp_valid(inst_rsp_valid), .inst_rsp_ack(inst_rsp_ack), .inst_rsp_data(inst_rsp_data),
        .data_rd(data_rd), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_wstrb(data_wstrb), .data_req_ack(data_req_ack), .data_rsp_valid(data_rsp_valid),
        .data_rsp_ack(data_rsp_ack), .data_rsp_data(data_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Settle point for sampling combinational outputs.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        inst_req_valid = 1'b0; inst_addr = 32'd0; inst_rsp_ack = 1'b0;
        data_rd = 1'b0; data_wr = 1'b0; data_addr = 32'd0; data_wdata = 32'd0;
        data_wstrb = 4'd0; data_rsp_ack = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ".mem_req_valid"},  {31'd0, mem_req_valid},  32'd0);
        chk({tag, ".inst_req_ack"},   {31'd0, inst_req_ack},   32'd0);
        chk({tag, ".data_req_ack"},   {31'd0, data_req_ack},   32'd0);
        chk({tag, ".inst_rsp_valid"}, {31'd0, inst_rsp_valid}, 32'd0);
        chk({tag, ".data_rsp_valid"}, {31'd0, data_rsp_valid}, 32'd0);
        chk({tag, ".mem_rsp_ready"},  {31'd0, mem_rsp_ready},  32'd0);
        chk({tag, ".mem_wen"},        {31'd0, mem_wen},        32'd0);
        chk({tag, ".mem_addr"},       mem_addr,                32'd0);
        chk({tag, ".mem_wdata"},      mem_wdata,               32'd0);
        chk({tag, ".mem_wstrb"},      {28'd0, mem_wstrb},      32'd0);
        chk({tag, ".inst_rsp_data"},  inst_rsp_data,           32'd0);
        chk({tag, ".data_rsp_data"},  data_rsp_data,           32'd0);
        chk({tag, ".conflict_cnt"},   conflict_cnt,            32'd0);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        mid();
        check_quiet("rst");
        cyc();
        rst = 1'b0;
        mid();
        check_quiet("post_rst");
        cyc();
    endtask

    initial begin
        bit exp_inst;
        rst = 1'b1;
        clear_inputs();
        do_reset();

        // Fetch only: IDLE, REQ, RSP wait, RSP handshake, back to IDLE.
        inst_req_valid = 1'b1; inst_addr = 32'h0000_0100;
        mid();
        chk("fetch.idle_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("fetch.idle_ack", {31'd0, inst_req_ack}, 32'd0);
        cyc();
        mem_req_ready = 1'b1;
        mid();
        chk("fetch.req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("fetch.req_addr", mem_addr, 32'h0000_0100);
        chk("fetch.req_wen", {31'd0, mem_wen}, 32'd0);
        chk("fetch.req_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("fetch.inst_ack", {31'd0, inst_req_ack}, 32'd1);
        chk("fetch.data_ack", {31'd0, data_req_ack}, 32'd0);
        cyc();
        inst_req_valid = 1'b0; mem_req_ready = 1'b0; inst_rsp_ack = 1'b1;
        mid();
        chk("fetch.rsp_wait_valid", {31'd0, inst_rsp_valid}, 32'd0);
        chk("fetch.rsp_ready", {31'd0, mem_rsp_ready}, 32'd1);
        cyc();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
        mid();
        chk("fetch.rsp_valid", {31'd0, inst_rsp_valid}, 32'd1);
        chk("fetch.rsp_data", inst_rsp_data, 32'h0000_0013);
        chk("fetch.data_rsp_valid", {31'd0, data_rsp_valid}, 32'd0);
        cyc();
        mid();
        chk("fetch.back_idle_valid", {31'd0, inst_rsp_valid}, 32'd0);
        chk("fetch.back_idle_req", {31'd0, mem_req_valid}, 32'd0);
        cyc();

        // Store: single write, ack pulse, no RSP.
        do_reset();
        data_wr = 1'b1; data_addr = 32'h0000_2000; data_wdata = 32'hDEAD_BEEF;
        data_wstrb = 4'h3; mem_req_ready = 1'b1; data_rsp_ack = 1'b1;
        mid();
        chk("store.idle_ack", {31'd0, data_req_ack}, 32'd0);
        cyc();
        mid();
        chk("store.valid", {31'd0, mem_req_valid}, 32'd1);
        chk("store.wen", {31'd0, mem_wen}, 32'd1);
        chk("store.addr", mem_addr, 32'h0000_2000);
        chk("store.wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("store.wstrb", {28'd0, mem_wstrb}, 32'd3);
        chk("store.data_ack", {31'd0, data_req_ack}, 32'd1);
        chk("store.inst_ack", {31'd0, inst_req_ack}, 32'd0);
        cyc();
        data_wr = 1'b0;
        mid();
        chk("store.no_rsp_ready", {31'd0, mem_rsp_ready}, 32'd0);
        chk("store.no_req", {31'd0, mem_req_valid}, 32'd0);
        cyc();

        // Contention: both channels read continuously for three transactions.
        do_reset();
        inst_req_valid = 1'b1; inst_addr = 32'h0000_0400;
        data_rd = 1'b1; data_addr = 32'h0000_0800;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        inst_rsp_ack = 1'b1; data_rsp_ack = 1'b1;
        for (int t = 0; t < 3; t++) begin
            exp_inst = RR ? (t % 2 == 0) : 1'b0;
            mem_rsp_data = 32'h1111_0000 + t;
            mid();
            chk("cont.idle_req", {31'd0, mem_req_valid}, 32'd0);
            cyc();
            mid();
            chk("cont.inst_ack", {31'd0, inst_req_ack}, {31'd0, exp_inst});
            chk("cont.data_ack", {31'd0, data_req_ack}, {31'd0, ~exp_inst});
            chk("cont.addr", mem_addr, exp_inst ? 32'h0000_0400 : 32'h0000_0800);
            chk("cont.req_no_rsp", {31'd0, inst_rsp_valid | data_rsp_valid}, 32'd0);
            cyc();
            mid();
            chk("cont.inst_rsp", {31'd0, inst_rsp_valid}, {31'd0, exp_inst});
            chk("cont.data_rsp", {31'd0, data_rsp_valid}, {31'd0, ~exp_inst});
            chk("cont.rsp_data", data_rsp_data, 32'h1111_0000 + t);
            cyc();
        end
        clear_inputs();
        mid();
        chk("cont.conflict_cnt", conflict_cnt, 32'd3);
        cyc();

        // Load with a stalled downstream for five cycles.
        do_reset();
        data_rd = 1'b1; data_addr = 32'h0000_3000;
        mid();
        cyc();
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("stall.valid", {31'd0, mem_req_valid}, 32'd1);
            chk("stall.addr", mem_addr, 32'h0000_3000);
            chk("stall.wen", {31'd0, mem_wen}, 32'd0);
            chk("stall.ack", {31'd0, data_req_ack}, 32'd0);
            cyc();
        end
        mem_req_ready = 1'b1;
        mid();
        chk("stall.accept_ack", {31'd0, data_req_ack}, 32'd1);
        cyc();
        data_rd = 1'b0; mem_req_ready = 1'b0; data_rsp_ack = 1'b1;
        inst_req_valid = 1'b1; inst_addr = 32'h0000_0700;
        mid();
        chk("stall.rsp_wait", {31'd0, data_rsp_valid}, 32'd0);
        chk("stall.ignore_inst", {31'd0, inst_req_ack | mem_req_valid}, 32'd0);
        cyc();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
        mid();
        chk("stall.data_rsp_valid", {31'd0, data_rsp_valid}, 32'd1);
        chk("stall.data_rsp_data", data_rsp_data, 32'hCAFE_F00D);
        chk("stall.inst_rsp_valid", {31'd0, inst_rsp_valid}, 32'd0);
        chk("stall.inst_rsp_data", inst_rsp_data, 32'hCAFE_F00D);
        cyc();

        // Reset while in RSP drops the response.
        do_reset();
        inst_req_valid = 1'b1; inst_addr = 32'h0000_0500;
        data_rd = 1'b1; data_addr = 32'h0000_0600; mem_req_ready = 1'b1;
        mid();
        cyc();
        mid();
        cyc();
        inst_req_valid = 1'b0; data_rd = 1'b0; mem_req_ready = 1'b0;
        mid();
        chk("rsprst.cnt_before", conflict_cnt, 32'd1);
        chk("rsprst.ready_no_ack", {31'd0, mem_rsp_ready}, 32'd0);
        cyc();
        rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0BAD;
        inst_rsp_ack = 1'b1; data_rsp_ack = 1'b1;
        mid();
        check_quiet("rsprst.during");
        cyc();
        rst = 1'b0;
        mid();
        check_quiet("rsprst.after");
        cyc();
        mem_rsp_valid = 1'b0;
        inst_req_valid = 1'b1; inst_addr = 32'h0000_0104; mem_req_ready = 1'b1;
        mid();
        cyc();
        mid();
        chk("rsprst.fetch_addr", mem_addr, 32'h0000_0104);
        chk("rsprst.fetch_ack", {31'd0, inst_req_ack}, 32'd1);
        cyc();
        inst_req_valid = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00A0_0093;
        mid();
        chk("rsprst.fetch_rsp_valid", {31'd0, inst_rsp_valid}, 32'd1);
        chk("rsprst.fetch_rsp_data", inst_rsp_data, 32'h00A0_0093);
        cyc();
        mid();
        chk("rsprst.idle_ignores_rsp", {31'd0, inst_rsp_valid}, 32'd0);
        chk("rsprst.idle_no_ready", {31'd0, mem_rsp_ready}, 32'd0);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
